rcpu_io_uart_tx: RTL and testbench

Memory-mapped IO responder for the RCPU IO bus. It answers the CPU's `io_read_enable`/`io_write_enable` accesses and drives a serial 8N1 UART transmit line from a small TX FIFO. It sits beside the RAM on the CPU's IO port. It gives the CPU a character output path with status polling and a programmable bit period.

---
 rtl/rcpu_io_pkg.sv | 29 ++
 rtl/rcpu_tx_fifo.sv | 62 ++++++
 rtl/rcpu_io_uart_tx.sv | 174 +++++++++++++++++
 tb/tb_rcpu_io_uart_tx.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rcpu_io_pkg.sv
// Shared constants and types for the RCPU IO UART transmitter.
package rcpu_io_pkg;

    // Word addresses on the IO bus
    localparam logic [15:0] IO_TX_DATA  = 16'h0000;
    localparam logic [15:0] IO_STATUS   = 16'h0001;
    localparam logic [15:0] IO_BAUD_DIV = 16'h0002;

    // STATUS bit positions, numbered MSB-first like the bus ([0:15])
    localparam int ST_EMPTY   = 15;
    localparam int ST_FULL    = 14;
    localparam int ST_BUSY    = 13;
    localparam int ST_OVF     = 12;
    localparam int ST_CNT_MSB = 8;
    localparam int ST_CNT_LSB = 11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_t;

    // A programmed divisor of zero behaves as one cycle per bit
    function automatic logic [15:0] eff_div(input logic [15:0] d);
        return (d == 16'd0) ? 16'd1 : d;
    endfunction

endpackage

// File: rtl/rcpu_tx_fifo.sv
// Small synchronous FIFO with first-word fall-through read data.
// Pushes into a full FIFO and pops from an empty one are ignored.
module rcpu_tx_fifo #(
    parameter  int DEPTH = 4,
    parameter  int W     = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_push,
    input  logic [W-1:0]  i_data,
    input  logic          i_pop,
    output logic [W-1:0]  o_data,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage array; contents need no reset since the count gates reads
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wr <= r_wr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd <= r_rd + AW'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/rcpu_io_uart_tx.sv
// IO-bus responder: TX FIFO, status/baud registers and an 8N1 serializer.
module rcpu_io_uart_tx
    import rcpu_io_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        io_read_enable,
    input  logic        io_write_enable,
    input  logic [0:15] io_address,
    input  logic [0:15] io_write_data,
    output logic [0:15] io_read_data,
    output logic        tx
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic            w_sel_tx;
    logic            w_sel_status;
    logic            w_sel_baud;
    logic            w_push;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;
    logic [CW-1:0]   w_count;
    logic [3:0]      w_cnt4;
    logic [7:0]      w_fifo_data;
    logic [0:15]     w_rmux;
    logic            w_bit_done;
    logic            w_tx;
    logic            w_busy;
    tx_state_t       w_next;

    tx_state_t       r_state;
    logic            r_ovf;
    logic [15:0]     r_baud;
    logic [0:15]     r_rdata;
    logic [15:0]     r_div;
    logic [15:0]     r_cnt;
    logic [2:0]      r_bit;
    logic [7:0]      r_shift;

    assign w_sel_tx     = (io_address == IO_TX_DATA);
    assign w_sel_status = (io_address == IO_STATUS);
    assign w_sel_baud   = (io_address == IO_BAUD_DIV);
    assign w_push       = io_write_enable && w_sel_tx;
    assign w_cnt4       = 4'(w_count);
    assign w_bit_done   = (r_cnt == r_div - 16'd1);
    assign io_read_data = r_rdata;
    assign tx           = w_tx;

    rcpu_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (8)
    ) u_fifo (
        .i_clk   (clk),
        .i_reset (reset),
        .i_push  (w_push),
        .i_data  (io_write_data[8:15]),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Sticky overflow: set by a dropped push, cleared by writing STATUS bit 12
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (w_push && w_full) begin
            r_ovf <= 1'b1;
        end else if (io_write_enable && w_sel_status && io_write_data[ST_OVF]) begin
            r_ovf <= 1'b0;
        end
    end

    // Programmable bit period; only sampled when a frame starts
    always_ff @(posedge clk) begin
        if (reset) begin
            r_baud <= 16'(CLKS_PER_BIT);
        end else if (io_write_enable && w_sel_baud) begin
            r_baud <= io_write_data;
        end
    end

    // Read mux built from pre-edge state so a same-cycle write reads the old value
    always_comb begin
        w_rmux = '0;
        if (w_sel_status) begin
            w_rmux[ST_EMPTY]              = w_empty;
            w_rmux[ST_FULL]               = w_full;
            w_rmux[ST_BUSY]               = w_busy;
            w_rmux[ST_OVF]                = r_ovf;
            w_rmux[ST_CNT_MSB:ST_CNT_LSB] = w_cnt4;
        end else if (w_sel_baud) begin
            w_rmux = r_baud;
        end
    end

    // Registered read data, held when no read is issued
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata <= '0;
        end else if (io_read_enable) begin
            r_rdata <= w_rmux;
        end
    end

    // Serializer state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Serializer next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (!w_empty) w_next = S_START;
            S_START: if (w_bit_done) w_next = S_DATA;
            S_DATA:  if (w_bit_done && (r_bit == 3'd7)) w_next = S_STOP;
            S_STOP:  if (w_bit_done) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Serializer outputs: line level, FIFO pop and busy flag
    always_comb begin
        w_pop  = (r_state == S_IDLE) && !w_empty;
        w_busy = (r_state != S_IDLE);
        case (r_state)
            S_START: w_tx = 1'b0;
            S_DATA:  w_tx = r_shift[0];
            default: w_tx = 1'b1;
        endcase
    end

    // Cycle-within-bit and bit-index counters
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            r_bit <= '0;
        end else if (w_pop) begin
            r_cnt <= '0;
            r_bit <= '0;
        end else if (r_state != S_IDLE) begin
            if (w_bit_done) begin
                r_cnt <= '0;
                if (r_state == S_DATA) begin
                    r_bit <= r_bit + 3'd1;
                end
            end else begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
    end

    // Frame byte and divisor captured at the pop; byte shifts out LSB first
    always_ff @(posedge clk) begin
        if (w_pop) begin
            r_shift <= w_fifo_data;
            r_div   <= eff_div(r_baud);
        end else if ((r_state == S_DATA) && w_bit_done) begin
            r_shift <= r_shift >> 1;
        end
    end

endmodule

// File: tb/tb_rcpu_io_uart_tx.sv
// Self-checking bench for rcpu_io_uart_tx: directed bus steps plus randomized
// frames, with the serial line recorded and compared to an expected waveform.
module tb_rcpu_io_uart_tx;

    localparam int DEPTH = 4;
    localparam int CPB   = 868;

    localparam logic [0:15] A_TX   = 16'h0000;
    localparam logic [0:15] A_STAT = 16'h0001;
    localparam logic [0:15] A_BAUD = 16'h0002;
    localparam logic [0:15] A_NONE = 16'h1234;

    logic        clk = 1'b0;
    logic        reset;
    logic        re;
    logic        we;
    logic [0:15] addr;
    logic [0:15] wdata;
    logic [0:15] rdata;
    logic        tx;

    int vectors     = 0;
    int miscompares = 0;

    logic       rec[$];
    logic [7:0] exp_bytes[8];
    int         exp_divs[8];

    rcpu_io_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .io_read_enable  (re),
        .io_write_enable (we),
        .io_address      (addr),
        .io_write_data   (wdata),
        .io_read_data    (rdata),
        .tx              (tx)
    );

    always #5 clk = ~clk;

    // One line sample per clock, taken mid-cycle
    always @(negedge clk) rec.push_back(tx);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // STATUS word from its documented fields, bit 0 = MSB
    function automatic logic [0:15] exp_status(input int cnt, input bit busy, input bit ovf);
        logic [0:15] s;
        logic [3:0]  c4;
        s     = '0;
        c4    = cnt[3:0];
        s[15] = (cnt == 0);
        s[14] = (cnt == DEPTH);
        s[13] = busy;
        s[12] = ovf;
        s[8:11] = c4;
        return s;
    endfunction

    function automatic int eff(input int d);
        return (d == 0) ? 1 : d;
    endfunction

    function automatic logic sample(input int idx);
        if (idx >= 0 && idx < rec.size()) return rec[idx];
        return 1'bx;
    endfunction

    task automatic bus_write(input logic [0:15] a, input logic [0:15] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        tick();
        we    = 1'b0;
    endtask

    task automatic bus_read(input logic [0:15] a, output logic [0:15] d);
        addr = a;
        re   = 1'b1;
        tick();
        re   = 1'b0;
        d    = rdata;
    endtask

    // Expected line: from the first low sample after base, n frames of
    // start/8 data LSB-first/stop, each bit eff(div) samples, one idle
    // sample between back-to-back frames, then idle to the end.
    task automatic check_frames(input string tag, input int base, input int n, input int first_at);
        int  i;
        bit  found;
        int  d;
        int  zeros;
        logic e;
        i     = base;
        found = 1'b0;
        while (i < rec.size()) begin
            if (rec[i] === 1'b0) begin
                found = 1'b1;
                break;
            end
            i++;
        end
        check({tag, " start found"}, 32'(found), 32'd1);
        if (!found) return;
        if (first_at >= 0) check({tag, " start index"}, i, first_at);
        for (int f = 0; f < n; f++) begin
            d = eff(exp_divs[f]);
            for (int b = 0; b < 10; b++) begin
                if (b == 0)      e = 1'b0;
                else if (b == 9) e = 1'b1;
                else             e = exp_bytes[f][b-1];
                for (int c = 0; c < d; c++) begin
                    check($sformatf("%s f%0d bit%0d cyc%0d", tag, f, b, c),
                          32'(sample(i + b * d + c)), 32'(e));
                end
            end
            i += 10 * d;
            if (f < n - 1) begin
                check($sformatf("%s gap%0d", tag, f), 32'(sample(i)), 32'd1);
                i++;
            end
        end
        zeros = 0;
        for (int k = i; k < rec.size(); k++) begin
            if (rec[k] !== 1'b1) zeros++;
        end
        check({tag, " trailing idle"}, zeros, 0);
    endtask

    initial begin
        logic [0:15] rd;
        logic [7:0]  b;
        int          s;
        int          n;
        int          dv;
        int          zeros;

        reset = 1'b1;
        re    = 1'b0;
        we    = 1'b0;
        addr  = '0;
        wdata = '0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check("reset tx", 32'(tx), 32'd1);
        check("reset rdata", 32'(rdata), 32'd0);
        bus_read(A_STAT, rd);
        check("reset status", 32'(rd), 32'(exp_status(0, 0, 0)));
        bus_read(A_BAUD, rd);
        check("reset baud", 32'(rd), CPB);

        // Single 0x55 frame at 4 cycles per bit
        bus_write(A_BAUD, 16'd4);
        bus_write(A_TX, 16'h0055);
        s = rec.size();
        bus_read(A_STAT, rd);
        check("count after push", 32'(rd), 32'(exp_status(1, 0, 0)));
        repeat (45) tick();
        exp_bytes[0] = 8'h55;
        exp_divs[0]  = 4;
        check_frames("b55", s, 1, s + 1);
        bus_read(A_STAT, rd);
        check("status after 55", 32'(rd), 32'(exp_status(0, 0, 0)));

        // Fill to overflow at divisor 1; upper data byte must be ignored
        bus_write(A_BAUD, 16'd1);
        for (int k = 0; k < 6; k++) begin
            b = 8'(8'h11 * (k + 1));
            bus_write(A_TX, {8'($urandom), b});
            if (k == 0) s = rec.size();
            if (k < 5) begin
                exp_bytes[k] = b;
                exp_divs[k]  = 1;
            end
        end
        bus_read(A_STAT, rd);
        check("overflow status", 32'(rd), 32'(exp_status(DEPTH, 1, 1)));
        bus_write(A_STAT, 16'h0008);
        bus_read(A_STAT, rd);
        check("overflow cleared", 32'(rd), 32'(exp_status(DEPTH, 1, 0)));
        repeat (70) tick();
        check_frames("fill", s, 5, s + 1);
        bus_read(A_STAT, rd);
        check("status after fill", 32'(rd), 32'(exp_status(0, 0, 0)));

        // Divisor change mid-frame applies to the following frame only
        bus_write(A_BAUD, 16'd8);
        exp_bytes[0] = 8'($urandom);
        exp_bytes[1] = 8'($urandom);
        exp_divs[0]  = 8;
        exp_divs[1]  = 2;
        bus_write(A_TX, {8'h00, exp_bytes[0]});
        s = rec.size();
        bus_write(A_TX, {8'h00, exp_bytes[1]});
        repeat (20) tick();
        bus_write(A_BAUD, 16'd2);
        bus_read(A_BAUD, rd);
        check("baud readback", 32'(rd), 32'd2);
        repeat (100) tick();
        check_frames("baudmid", s, 2, s + 1);

        // Reset in the middle of the data bits, with a second byte queued
        bus_write(A_BAUD, 16'd4);
        bus_write(A_TX, {8'h00, 8'($urandom)});
        bus_write(A_TX, {8'h00, 8'($urandom)});
        repeat (15) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midreset tx", 32'(tx), 32'd1);
        check("midreset rdata", 32'(rdata), 32'd0);
        s = rec.size();
        bus_read(A_STAT, rd);
        check("midreset status", 32'(rd), 32'(exp_status(0, 0, 0)));
        bus_read(A_BAUD, rd);
        check("midreset baud", 32'(rd), CPB);
        repeat (60) tick();
        zeros = 0;
        for (int k = s; k < rec.size(); k++) begin
            if (rec[k] !== 1'b1) zeros++;
        end
        check("no residual frame", zeros, 0);

        // Unmapped address reads 0 and ignores writes
        bus_read(A_NONE, rd);
        check("unmapped read", 32'(rd), 32'd0);
        bus_write(A_NONE, 16'(CPB ^ 16'hFFFF));
        bus_read(A_STAT, rd);
        check("unmapped write status", 32'(rd), 32'(exp_status(0, 0, 0)));
        bus_read(A_BAUD, rd);
        check("unmapped write baud", 32'(rd), CPB);

        // Same-cycle read and write of BAUD_DIV returns the old value
        addr  = A_BAUD;
        wdata = 16'd3;
        re    = 1'b1;
        we    = 1'b1;
        tick();
        re    = 1'b0;
        we    = 1'b0;
        check("rw same addr old", 32'(rdata), CPB);
        bus_read(A_BAUD, rd);
        check("rw same addr new", 32'(rd), 32'd3);
        repeat (3) tick();
        check("rdata hold", 32'(rdata), 32'd3);

        // Randomized bursts, including divisor 0
        for (int it = 0; it < 6; it++) begin
            dv = $urandom_range(0, 3);
            n  = $urandom_range(1, DEPTH);
            bus_write(A_BAUD, 16'(dv));
            for (int k = 0; k < n; k++) begin
                exp_bytes[k] = 8'($urandom);
                exp_divs[k]  = dv;
                bus_write(A_TX, {8'($urandom), exp_bytes[k]});
                if (k == 0) s = rec.size();
            end
            repeat (n * (10 * eff(dv) + 1) + 10) tick();
            check_frames($sformatf("rnd%0d", it), s, n, s + 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
